frame_row_buf_ctrl: RTL

Controller that owns both ports of the intra top-row line buffer (a 32-bit × 480-word dual-port RAM with active-low controls and registered read data). It writes bursts of packed reconstructed bottom-row pixels from the reconstruction stage through port A. It reads bursts of top-neighbour pixels for the intra predictor through port B. It sits between recon/intra-pred and the RAM, and resolves same-cycle read/write address collisions.

---
 rtl/frame_row_buf_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/frame_row_buf_ctrl.sv
// frame_row_buf_ctrl: owns both ports of the intra top-row line buffer RAM
// (active-low controls, registered read data). Port A carries write bursts of
// reconstructed bottom-row pixels; port B carries read bursts of top-neighbour
// pixels. Same-cycle same-address read/write collisions are resolved here.
// Optional feature macro: FRAME_ROW_BYPASS_EN
//   defined   : colliding read proceeds, its word is replaced by the write data
//   undefined : colliding read is held off one cycle and re-issued
module frame_row_buf_ctrl #(
    parameter int Word_Width = 32,
    parameter int Addr_Width = 9,
    parameter int Depth      = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_start_i,
    input  logic [Addr_Width-1:0] wr_addr_i,
    input  logic [3:0]            wr_len_i,
    input  logic                  wr_val_i,
    input  logic [Word_Width-1:0] wr_data_i,
    output logic                  wr_busy_o,
    output logic                  wr_done_o,
    input  logic                  rd_start_i,
    input  logic [Addr_Width-1:0] rd_addr_i,
    input  logic [3:0]            rd_len_i,
    output logic                  rd_val_o,
    output logic [Word_Width-1:0] rd_data_o,
    output logic                  rd_busy_o,
    output logic                  rd_done_o,
    output logic                  cena_o,
    output logic                  wena_o,
    output logic                  oena_o,
    output logic [Addr_Width-1:0] addra_o,
    output logic [Word_Width-1:0] dataa_o,
    output logic                  cenb_o,
    output logic                  wenb_o,
    output logic                  oenb_o,
    output logic [Addr_Width-1:0] addrb_o,
    input  logic [Word_Width-1:0] datab_i
);

    localparam logic [Addr_Width-1:0] DEPTH_A   = Addr_Width'(Depth);
    localparam logic [Addr_Width-1:0] LAST_ADDR = Addr_Width'(Depth - 1);

    typedef enum logic {W_IDLE, W_BUSY} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN} r_state_t;

    // Start addresses beyond the buffer fold back by one Depth.
    function automatic logic [Addr_Width-1:0] wrap_start(input logic [Addr_Width-1:0] a);
        return (a >= DEPTH_A) ? (a - DEPTH_A) : a;
    endfunction

    function automatic logic [Addr_Width-1:0] addr_inc(input logic [Addr_Width-1:0] a);
        return (a == LAST_ADDR) ? '0 : (a + Addr_Width'(1));
    endfunction

    // Burst length field: 0 means 16 words.
    function automatic logic [4:0] len_decode(input logic [3:0] l);
        return (l == 4'd0) ? 5'd16 : {1'b0, l};
    endfunction

    w_state_t              w_state_q, w_state_d;
    logic [Addr_Width-1:0] waddr_q, waddr_d;
    logic [4:0]            wcnt_q, wcnt_d;
    logic                  cena_q, cena_d;
    logic [Addr_Width-1:0] addra_q, addra_d;
    logic [Word_Width-1:0] dataa_q, dataa_d;
    logic                  wr_done_q, wr_done_d;

    r_state_t              r_state_q, r_state_d;
    logic [Addr_Width-1:0] raddr_q, raddr_d;
    logic [4:0]            rcnt_q, rcnt_d;
    logic                  ram_vld_q, ram_vld_d;
    logic                  ram_last_q, ram_last_d;
    logic                  byp_q, byp_d;
    logic [Word_Width-1:0] byp_data_q, byp_data_d;
    logic                  rd_val_q, rd_val_d;
    logic                  rd_done_q, rd_done_d;
    logic [Word_Width-1:0] rd_data_q, rd_data_d;

    logic coll, rd_iss, rd_byp;

    // Write FSM next state: each accepted wr_val_i becomes one port-A write next cycle.
    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wcnt_d    = wcnt_q;
        cena_d    = 1'b1;
        addra_d   = addra_q;
        dataa_d   = dataa_q;
        wr_done_d = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                // The done cycle still reports busy, so a start there is ignored.
                if (wr_start_i && !wr_done_q) begin
                    w_state_d = W_BUSY;
                    waddr_d   = wrap_start(wr_addr_i);
                    wcnt_d    = len_decode(wr_len_i);
                end
            end
            W_BUSY: begin
                if (wr_val_i) begin
                    cena_d  = 1'b0;
                    addra_d = waddr_q;
                    dataa_d = wr_data_i;
                    waddr_d = addr_inc(waddr_q);
                    wcnt_d  = wcnt_q - 5'd1;
                    if (wcnt_q == 5'd1) begin
                        wr_done_d = 1'b1;
                        w_state_d = W_IDLE;
                    end
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Collision detection against the write currently presented on port A.
    always_comb begin
        coll = (r_state_q == R_ISSUE) && !cena_q && (addra_q == raddr_q);
`ifdef FRAME_ROW_BYPASS_EN
        rd_iss = (r_state_q == R_ISSUE);
        rd_byp = coll;
`else
        rd_iss = (r_state_q == R_ISSUE) && !coll;
        rd_byp = 1'b0;
`endif
    end

    // Read FSM next state plus the two-stage return path (RAM register, output register).
    always_comb begin
        r_state_d  = r_state_q;
        raddr_d    = raddr_q;
        rcnt_d     = rcnt_q;
        ram_vld_d  = rd_iss;
        ram_last_d = rd_iss && (rcnt_q == 5'd1);
        byp_d      = rd_byp;
        byp_data_d = rd_byp ? dataa_q : byp_data_q;
        rd_val_d   = ram_vld_q;
        rd_done_d  = ram_vld_q && ram_last_q;
        rd_data_d  = rd_data_q;
        if (ram_vld_q) begin
            rd_data_d = byp_q ? byp_data_q : datab_i;
        end
        case (r_state_q)
            R_IDLE: begin
                if (rd_start_i) begin
                    r_state_d = R_ISSUE;
                    raddr_d   = wrap_start(rd_addr_i);
                    rcnt_d    = len_decode(rd_len_i);
                end
            end
            R_ISSUE: begin
                if (rd_iss) begin
                    raddr_d = addr_inc(raddr_q);
                    rcnt_d  = rcnt_q - 5'd1;
                    if (rcnt_q == 5'd1) begin
                        r_state_d = R_DRAIN;
                    end
                end
            end
            R_DRAIN: begin
                if (rd_done_q) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // State and port registers; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q  <= W_IDLE;
            waddr_q    <= '0;
            wcnt_q     <= '0;
            cena_q     <= 1'b1;
            addra_q    <= '0;
            dataa_q    <= '0;
            wr_done_q  <= 1'b0;
            r_state_q  <= R_IDLE;
            raddr_q    <= '0;
            rcnt_q     <= '0;
            ram_vld_q  <= 1'b0;
            ram_last_q <= 1'b0;
            byp_q      <= 1'b0;
            rd_val_q   <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            w_state_q  <= w_state_d;
            waddr_q    <= waddr_d;
            wcnt_q     <= wcnt_d;
            cena_q     <= cena_d;
            addra_q    <= addra_d;
            dataa_q    <= dataa_d;
            wr_done_q  <= wr_done_d;
            r_state_q  <= r_state_d;
            raddr_q    <= raddr_d;
            rcnt_q     <= rcnt_d;
            ram_vld_q  <= ram_vld_d;
            ram_last_q <= ram_last_d;
            byp_q      <= byp_d;
            rd_val_q   <= rd_val_d;
            rd_done_q  <= rd_done_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Bypass word holding register; only consumed when byp_q qualifies it.
    always_ff @(posedge clk) begin
        byp_data_q <= byp_data_d;
    end

    assign cena_o    = cena_q;
    assign wena_o    = cena_q;
    assign oena_o    = 1'b1;
    assign addra_o   = addra_q;
    assign dataa_o   = dataa_q;
    assign cenb_o    = ~rd_iss;
    assign wenb_o    = 1'b1;
    assign oenb_o    = 1'b0;
    assign addrb_o   = raddr_q;
    assign wr_done_o = wr_done_q;
    assign wr_busy_o = (w_state_q == W_BUSY) | wr_done_q;
    assign rd_val_o  = rd_val_q;
    assign rd_data_o = rd_data_q;
    assign rd_done_o = rd_done_q;
    assign rd_busy_o = (r_state_q != R_IDLE);

endmodule
